// File: rtl/chu_gpo_pulse.sv
// Slot GPO core with atomic set/clear/toggle, per-bit blink, a retriggerable
// one-shot pulse overlay and full register readback.
module chu_gpo_pulse #(
    parameter int W  = 8,
    parameter int CW = 24
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic [W-1:0]  dout
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } pstate_t;

    logic [W-1:0]  data_q, data_d;
    logic [W-1:0]  blink_mask_q, blink_mask_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [W-1:0]  pulse_mask_q, pulse_mask_d;
    logic [CW-1:0] pulse_len_q, pulse_len_d;
    logic [CW-1:0] pcnt_q, pcnt_d;
    pstate_t       state_q, state_d;
    logic [W-1:0]  dout_q, dout_d;

    logic          wr_en_s;
    logic          wr_period_s;
    logic          wr_pulse_s;
    logic [W-1:0]  wmask_s;
    logic [CW-1:0] wlen_s;
    logic          busy_s;
    logic          unused_ok;

    // Strobes are side-effect free; upper write bits are dropped by design.
    assign unused_ok = ^{read, wr_data};

    assign wr_en_s = cs & write & ~addr[4];
    assign wmask_s = wr_data[W-1:0];
    assign wlen_s  = wr_data[CW-1:0];
    assign busy_s  = (state_q == ACTIVE);

    // Next-state logic: register writes, blink counter, pulse FSM and output.
    always_comb begin
        data_d       = data_q;
        blink_mask_d = blink_mask_q;
        period_d     = period_q;
        pulse_len_d  = pulse_len_q;
        wr_period_s  = 1'b0;
        wr_pulse_s   = 1'b0;

        if (wr_en_s) begin
            case (addr[3:0])
                4'd0:    data_d       = wmask_s;
                4'd1:    data_d       = data_q | wmask_s;
                4'd2:    data_d       = data_q & ~wmask_s;
                4'd3:    data_d       = data_q ^ wmask_s;
                4'd4:    blink_mask_d = wmask_s;
                4'd5: begin
                    period_d    = wlen_s;
                    wr_period_s = 1'b1;
                end
                4'd6:    wr_pulse_s   = 1'b1;
                4'd7:    pulse_len_d  = wlen_s;
                default: data_d       = data_q;
            endcase
        end else begin
            data_d = data_q;
        end

        // A PERIOD write restarts the half-period from a known phase.
        if (wr_period_s) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (period_q != '0) begin
            if (cnt_q == period_q - CW'(1)) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                phase_d = phase_q;
            end
        end else begin
            cnt_d   = cnt_q;
            phase_d = phase_q;
        end

        pulse_mask_d = pulse_mask_q;
        if (wr_pulse_s && (wmask_s == '0)) begin
            pcnt_d  = '0;
            state_d = IDLE;
        end else if (wr_pulse_s && (pulse_len_q != '0)) begin
            pulse_mask_d = wmask_s;
            pcnt_d       = pulse_len_q;
            state_d      = ACTIVE;
        end else if (state_q == ACTIVE) begin
            // The last counted cycle is the one where pcnt leaves 1.
            pcnt_d  = pcnt_q - CW'(1);
            state_d = (pcnt_q == CW'(1)) ? IDLE : ACTIVE;
        end else begin
            pcnt_d  = pcnt_q;
            state_d = state_q;
        end

        dout_d = (data_q & ~blink_mask_q)
               | (blink_mask_q & {W{phase_q}})
               | (busy_s ? pulse_mask_q : {W{1'b0}});
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q       <= '0;
            blink_mask_q <= '0;
            period_q     <= '0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            pulse_mask_q <= '0;
            pulse_len_q  <= '0;
            pcnt_q       <= '0;
            state_q      <= IDLE;
            dout_q       <= '0;
        end else begin
            data_q       <= data_d;
            blink_mask_q <= blink_mask_d;
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            pulse_mask_q <= pulse_mask_d;
            pulse_len_q  <= pulse_len_d;
            pcnt_q       <= pcnt_d;
            state_q      <= state_d;
            dout_q       <= dout_d;
        end
    end

    assign dout = dout_q;

    // Readback mux; high half of the address space reads as zero.
    always_comb begin
        rd_data = 32'd0;
        if (addr[4]) begin
            rd_data = 32'd0;
        end else begin
            case (addr[3:0])
                4'd0, 4'd1, 4'd2, 4'd3: rd_data = 32'(data_q);
                4'd4:    rd_data = 32'(blink_mask_q);
                4'd5:    rd_data = 32'(period_q);
                4'd6:    rd_data = 32'(pulse_mask_q);
                4'd7:    rd_data = 32'(pulse_len_q);
                4'd8:    rd_data = 32'(dout_q);
                4'd9:    rd_data = {30'd0, phase_q, busy_s};
                default: rd_data = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_chu_gpo_pulse.sv
// Scoreboard bench for chu_gpo_pulse: a time-based reference model predicts
// readback and dout; a monitor pops predictions and compares.
module tb_chu_gpo_pulse;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  addr = 5'd0;
    logic [31:0] wr_data = 32'd0;
    logic [31:0] rd_data;
    logic [7:0]  dout;

    chu_gpo_pulse #(.W(8), .CW(24)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .dout(dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          chk_rd;
        logic [4:0]  a;
        logic [31:0] rd;
        logic [7:0]  dout;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: time-stamped events instead of counters.
    logic [7:0] m_data = 8'd0, m_bmask = 8'd0, m_pmask = 8'd0, m_dout = 8'd0;
    int m_P = 0, m_pw = 0, m_L = 0, m_until = 0, m_n = 0;

    function automatic bit m_phase();
        if (m_P == 0) return 1'b0;
        return ((((m_n - m_pw) / m_P) % 2) == 1);
    endfunction

    function automatic bit m_busy();
        return (m_n < m_until);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        logic [31:0] p;
        p = 32'(m_P) & 32'h00FF_FFFF;
        if (a[4]) return 32'd0;
        case (a[3:0])
            4'd0, 4'd1, 4'd2, 4'd3: return {24'd0, m_data};
            4'd4: return {24'd0, m_bmask};
            4'd5: return p;
            4'd6: return {24'd0, m_pmask};
            4'd7: return 32'(m_L);
            4'd8: return {24'd0, m_dout};
            4'd9: return {30'd0, m_phase(), m_busy()};
            default: return 32'd0;
        endcase
    endfunction

    task automatic cyc(input bit rst, input bit c, input bit w,
                       input logic [4:0] a, input logic [31:0] d, input bit chk);
        exp_t e;
        logic [7:0] nxt;
        int n1;
        @(negedge clk);
        reset = rst; cs = c; write = w; read = c & ~w; addr = a; wr_data = d;
        e.chk_rd = chk;
        e.a = a;
        e.rd = m_read(a);
        nxt = (m_data & ~m_bmask) | (m_bmask & {8{m_phase()}}) | (m_busy() ? m_pmask : 8'd0);
        n1 = m_n + 1;
        if (rst) begin
            m_data = 8'd0; m_bmask = 8'd0; m_pmask = 8'd0;
            m_P = 0; m_pw = n1; m_L = 0; m_until = 0; nxt = 8'd0;
        end else if (c && w && !a[4]) begin
            case (a[3:0])
                4'd0: m_data = d[7:0];
                4'd1: m_data = m_data | d[7:0];
                4'd2: m_data = m_data & ~d[7:0];
                4'd3: m_data = m_data ^ d[7:0];
                4'd4: m_bmask = d[7:0];
                4'd5: begin m_P = int'(d[23:0]); m_pw = n1; end
                4'd6: begin
                    if (d[7:0] == 8'd0) m_until = 0;
                    else if (m_L != 0) begin m_pmask = d[7:0]; m_until = n1 + m_L; end
                end
                4'd7: m_L = int'(d[23:0]);
                default: ;
            endcase
        end
        m_n = n1;
        m_dout = nxt;
        e.dout = nxt;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b1, a, d, 1'b1);
    endtask

    task automatic rd(input logic [4:0] a);
        cyc(1'b0, 1'b1, 1'b0, a, 32'd0, 1'b1);
    endtask

    // Monitor: rd_data checked mid-cycle, dout checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_rd) begin
                    checks++;
                    if (rd_data !== e.rd) begin
                        errors++;
                        $display("FAIL rd_data addr=%0d got=%h exp=%h t=%0t", e.a, rd_data, e.rd, $time);
                    end
                end
                @(posedge clk);
                #1;
                checks++;
                if (dout !== e.dout) begin
                    errors++;
                    $display("FAIL dout got=%h exp=%h t=%0t", dout, e.dout, $time);
                end
            end
        end
    end

    initial begin
        logic [4:0]  a;
        logic [31:0] d;
        int r;
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        for (int i = 0; i < 32; i++) rd(5'(i));
        // Plain data path and atomic updates
        wr(5'd0, 32'hA5); rd(5'd0); rd(5'd8);
        wr(5'd0, 32'hF0); wr(5'd1, 32'h0F); rd(5'd8);
        wr(5'd2, 32'h81); rd(5'd8); wr(5'd3, 32'hFF); rd(5'd8);
        wr(5'd0, 32'h1FF); rd(5'd0); rd(5'd8);
        // Blink then freeze
        wr(5'd5, 32'd4); wr(5'd4, 32'h01); wr(5'd0, 32'h00);
        for (int i = 0; i < 12; i++) rd(5'd9);
        wr(5'd5, 32'd0);
        for (int i = 0; i < 6; i++) rd(5'd8);
        wr(5'd4, 32'h00);
        // Pulse and retrigger
        wr(5'd7, 32'd5); wr(5'd6, 32'h80); rd(5'd9); rd(5'd9);
        wr(5'd6, 32'h40);
        for (int i = 0; i < 7; i++) rd(5'd9);
        // Cancel and zero-length pulse
        wr(5'd6, 32'h10); rd(5'd9); wr(5'd6, 32'h00);
        for (int i = 0; i < 3; i++) rd(5'd9);
        wr(5'd7, 32'd0); wr(5'd6, 32'hFF);
        for (int i = 0; i < 3; i++) rd(5'd8);
        // Reset mid pulse + blink, then out-of-range writes
        wr(5'd5, 32'd3); wr(5'd4, 32'h0F); wr(5'd7, 32'd20); wr(5'd6, 32'hF0);
        rd(5'd8); rd(5'd8);
        cyc(1'b1, 1'b1, 1'b0, 5'd8, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) rd(5'(i));
        wr(5'h10, 32'hFF); wr(5'h15, 32'h7); wr(5'h0C, 32'h55);
        for (int i = 0; i < 10; i++) rd(5'(i));
        // Randomised traffic
        for (int i = 0; i < 1500; i++) begin
            r = int'($urandom_range(0, 99));
            a = 5'($urandom_range(0, 11));
            if ($urandom_range(0, 9) == 0) a = a | 5'h10;
            d = $urandom;
            if (a[3:0] == 4'd5 || a[3:0] == 4'd7) d = 32'($urandom_range(0, 6)) | (d & 32'hFF00_0000);
            if (r == 0) cyc(1'b1, 1'b0, 1'b0, a, 32'd0, 1'b1);
            else if (r < 45) wr(a, d);
            else if (r < 90) rd(a);
            else cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), a, d, 1'b1);
        end
        repeat (3) @(posedge clk);
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
